// File: rtl/segasys1_sndcmd.sv
// Sound-command mailbox: queues main-CPU command bytes for the sound CPU and
// raises one NMI pulse per queued byte, with a guaranteed low gap between pulses.
module segasys1_sndcmd #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned NMI_LEN    = 8
) (
    input  logic       CLK48M,
    input  logic       RESET,
    input  logic       SNDRQ,
    input  logic [7:0] SNDNO,
    input  logic       SCPU_CLK_EN,
    input  logic       SCPU_RD,
    output logic [7:0] SCPU_DO,
    output logic       SCPU_NMI,
    output logic       PENDING,
    output logic       OVF
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = $clog2(NMI_LEN + 1);

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [CNT_W-1:0]      TICK_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]      TICK_LEN = CNT_W'(NMI_LEN);

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StWait,
        StGap
    } nmi_state_t;

    logic                  rq_d;
    logic                  rd_d;
    logic                  push;
    logic                  pop;
    logic                  do_push;
    logic                  do_pop;
    logic                  empty;
    logic                  full;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [7:0]            last_q;
    logic                  ovf_q;

    nmi_state_t            state_q;
    nmi_state_t            state_d;
    logic [CNT_W-1:0]      tick_q;
    logic [CNT_W-1:0]      tick_d;
    logic                  served_q;
    logic                  served_d;

    assign push  = SNDRQ & ~rq_d;
    assign pop   = SCPU_RD & ~rd_d;
    assign empty = (count_q == '0);
    // count never exceeds DEPTH, so its top bit alone marks a full queue
    assign full  = count_q[DEPTH_LOG2];

    // A pop in the same cycle frees the slot the push is about to reuse
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            rq_d     <= 1'b0;
            rd_d     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rq_d <= SNDRQ;
            rd_d <= SCPU_RD;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                last_q   <= mem[rd_ptr_q];
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_ONE;
            end
            if (push && !do_push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK48M) begin
        if (!RESET && do_push) begin
            mem[wr_ptr_q] <= SNDNO;
        end
    end

    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            state_q  <= StIdle;
            tick_q   <= '0;
            served_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            served_q <= served_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        served_d = served_q;
        if ((state_q == StAssert || state_q == StWait) && pop) begin
            served_d = 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d  = StAssert;
                    tick_d   = TICK_LEN;
                    served_d = 1'b0;
                end
            end
            StAssert: begin
                if (SCPU_CLK_EN) begin
                    tick_d = tick_q - TICK_ONE;
                    if (tick_q == TICK_ONE) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (served_q || pop) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                // hold NMI low for at least one sound-CPU clock
                if (SCPU_CLK_EN) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign SCPU_NMI = (state_q == StAssert);
    assign PENDING  = ~empty;
    assign SCPU_DO  = empty ? last_q : mem[rd_ptr_q];
    assign OVF      = ovf_q;

endmodule

// File: tb/tb_segasys1_sndcmd.sv
// Bench for segasys1_sndcmd: constant vector table, hand sequences for NMI timing,
// and a randomized run checked against a queue model plus NMI width/gap rules.
module tb_segasys1_sndcmd;

    localparam int unsigned DEPTH_LOG2 = 2;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
    localparam int unsigned NMI_LEN    = 8;

    logic       CLK48M;
    logic       RESET;
    logic       SNDRQ;
    logic [7:0] SNDNO;
    logic       SCPU_CLK_EN;
    logic       SCPU_RD;
    logic [7:0] SCPU_DO;
    logic       SCPU_NMI;
    logic       PENDING;
    logic       OVF;

    segasys1_sndcmd #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .NMI_LEN   (NMI_LEN)
    ) dut (
        .CLK48M     (CLK48M),
        .RESET      (RESET),
        .SNDRQ      (SNDRQ),
        .SNDNO      (SNDNO),
        .SCPU_CLK_EN(SCPU_CLK_EN),
        .SCPU_RD    (SCPU_RD),
        .SCPU_DO    (SCPU_DO),
        .SCPU_NMI   (SCPU_NMI),
        .PENDING    (PENDING),
        .OVF        (OVF)
    );

    initial CLK48M = 1'b0;
    always #5 CLK48M = ~CLK48M;

    typedef struct {
        logic       rst;
        logic       rq;
        logic [7:0] no;
        logic       rd;
        logic       pend;
        logic [7:0] dout;
        logic       ovf;
        logic       nmi;
    } vec_t;

    vec_t tbl[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned en_mode = 0;
    logic        en_prev = 1'b0;

    // reference model state
    logic [7:0]  mq[$];
    logic [7:0]  m_last = 8'h00;
    logic        m_ovf = 1'b0;
    logic        m_prq = 1'b0;
    logic        m_prd = 1'b0;

    // NMI rule tracking
    int unsigned hi_ticks = 0;
    int unsigned lo_ticks = 0;
    logic        seen_pulse = 1'b0;
    logic        pulse_valid = 1'b0;
    int unsigned n_pulses = 0;

    function automatic vec_t mk(logic rst, logic rq, logic [7:0] no, logic rd,
                                logic pend, logic [7:0] dout, logic ovf, logic nmi);
        vec_t v;
        v.rst = rst; v.rq = rq; v.no = no; v.rd = rd;
        v.pend = pend; v.dout = dout; v.ovf = ovf; v.nmi = nmi;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic nmi_now, en_now, rst_now, push, pop;
        case (en_mode)
            0:       SCPU_CLK_EN = 1'b0;
            1:       SCPU_CLK_EN = (cyc % 3 == 0);
            default: SCPU_CLK_EN = !en_prev && ($urandom_range(0, 2) == 0);
        endcase
        en_prev = SCPU_CLK_EN;
        nmi_now = SCPU_NMI;
        en_now  = SCPU_CLK_EN;
        rst_now = RESET;
        if (RESET) begin
            mq.delete();
            m_last = 8'h00;
            m_ovf  = 1'b0;
            m_prq  = 1'b0;
            m_prd  = 1'b0;
        end else begin
            push  = SNDRQ & ~m_prq;
            pop   = SCPU_RD & ~m_prd;
            m_prq = SNDRQ;
            m_prd = SCPU_RD;
            if (pop && mq.size() != 0) m_last = mq.pop_front();
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(SNDNO);
                else m_ovf = 1'b1;
            end
        end
        @(posedge CLK48M);
        #1;
        cyc++;
        chk("model_pending", PENDING, mq.size() != 0);
        chk("model_do", SCPU_DO, (mq.size() != 0) ? mq[0] : m_last);
        chk("model_ovf", OVF, m_ovf);
        if (rst_now) begin
            chk("reset_nmi", SCPU_NMI, 1'b0);
            hi_ticks = 0; lo_ticks = 0; seen_pulse = 1'b0; pulse_valid = 1'b0;
        end else begin
            if (en_now) begin
                if (nmi_now) hi_ticks++;
                else lo_ticks++;
            end
            if (nmi_now && !SCPU_NMI && pulse_valid) begin
                chk("nmi_width", hi_ticks, NMI_LEN);
                seen_pulse = 1'b1; pulse_valid = 1'b0; lo_ticks = 0;
            end
            if (!nmi_now && SCPU_NMI) begin
                if (seen_pulse) chk("nmi_gap", lo_ticks != 0, 1'b1);
                hi_ticks = 0; pulse_valid = 1'b1; n_pulses++;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        RESET = 1'b1; SNDRQ = 1'b0; SCPU_RD = 1'b0;
        tick();
        RESET = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        SNDRQ = 1'b1; SNDNO = b; tick();
        SNDRQ = 1'b0; tick();
    endtask

    task automatic read_pulse();
        SCPU_RD = 1'b1; tick();
        SCPU_RD = 1'b0; tick();
    endtask

    task automatic wait_nmi(input logic lvl, input string nm);
        for (int i = 0; i < 400 && SCPU_NMI !== lvl; i++) tick();
        chk(nm, SCPU_NMI, lvl);
    endtask

    int unsigned p0;
    int unsigned rd_prob;

    initial begin
        RESET = 1'b1; SNDRQ = 1'b0; SNDNO = 8'h00; SCPU_CLK_EN = 1'b0; SCPU_RD = 1'b0;

        // rst rq no rd | pend do ovf nmi   (no sound-CPU clock: NMI stays high once raised)
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 8'h33, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h5A, 0, 1, 8'h5A, 0, 0));
        tbl.push_back(mk(0, 1, 8'h00, 0, 1, 8'h5A, 0, 1));
        tbl.push_back(mk(0, 1, 8'h00, 0, 1, 8'h5A, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h5A, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h5A, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h5A, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h5A, 0, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mk(0, 1, 8'h10 + 8'(i), 0, 1, 8'h10, i == 4, i != 0));
            tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h10, i == 4, 1));
        end
        for (int i = 1; i < 4; i++) begin
            tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h10 + 8'(i), 1, 1));
            tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h10 + 8'(i), 1, 1));
        end
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h13, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h13, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h13, 1, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'hA0, 0, 1, 8'hA0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'hA0, 0, 1));
        tbl.push_back(mk(0, 1, 8'hA1, 0, 1, 8'hA0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'hA0, 0, 1));
        tbl.push_back(mk(0, 1, 8'hA2, 1, 1, 8'hA1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'hA1, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'hA2, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'hA2, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'hA2, 0, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h77, 1, 1, 8'h77, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 8'h77, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h77, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h77, 0, 1));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 0));

        en_mode = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            RESET = tbl[i].rst; SNDRQ = tbl[i].rq; SNDNO = tbl[i].no; SCPU_RD = tbl[i].rd;
            tick();
            chk($sformatf("vec%0d_pending", i), PENDING, tbl[i].pend);
            chk($sformatf("vec%0d_do", i), SCPU_DO, tbl[i].dout);
            chk($sformatf("vec%0d_ovf", i), OVF, tbl[i].ovf);
            chk($sformatf("vec%0d_nmi", i), SCPU_NMI, tbl[i].nmi);
        end
        RESET = 1'b0; SNDRQ = 1'b0; SCPU_RD = 1'b0;

        // single command held for 6 cycles, with a running sound-CPU clock
        en_mode = 1;
        do_reset();
        p0 = n_pulses;
        SNDRQ = 1'b1; SNDNO = 8'h5A;
        tick();
        chk("single_t1_pending", PENDING, 1'b1);
        chk("single_t1_nmi", SCPU_NMI, 1'b0);
        tick();
        chk("single_t2_nmi", SCPU_NMI, 1'b1);
        ticks(4);
        SNDRQ = 1'b0;
        wait_nmi(1'b0, "single_nmi_fall");
        read_pulse();
        chk("single_pending_after_read", PENDING, 1'b0);
        chk("single_do_after_read", SCPU_DO, 8'h5A);
        ticks(60);
        chk("single_pulse_count", n_pulses - p0, 1);

        // burst of three, one read per NMI
        do_reset();
        p0 = n_pulses;
        send(8'h01); send(8'h02); send(8'h03);
        for (int k = 0; k < 3; k++) begin
            wait_nmi(1'b1, "burst_nmi_rise");
            wait_nmi(1'b0, "burst_nmi_fall");
            chk("burst_do", SCPU_DO, 8'(k + 1));
            read_pulse();
        end
        ticks(60);
        chk("burst_pulse_count", n_pulses - p0, 3);
        chk("burst_pending", PENDING, 1'b0);
        chk("burst_do_last", SCPU_DO, 8'h03);

        // read during the pulse: full width, no second NMI
        do_reset();
        p0 = n_pulses;
        send(8'h5A);
        wait_nmi(1'b1, "early_nmi_rise");
        tick();
        read_pulse();
        chk("early_still_high", SCPU_NMI, 1'b1);
        wait_nmi(1'b0, "early_nmi_fall");
        ticks(60);
        chk("early_pulse_count", n_pulses - p0, 1);
        chk("early_pending", PENDING, 1'b0);

        // reset in the middle of a pulse with two queued
        do_reset();
        send(8'h21); send(8'h22);
        wait_nmi(1'b1, "rstmid_nmi_rise");
        ticks(2);
        chk("rstmid_high_before", SCPU_NMI, 1'b1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rstmid_nmi", SCPU_NMI, 1'b0);
        chk("rstmid_pending", PENDING, 1'b0);
        chk("rstmid_do", SCPU_DO, 8'h00);
        chk("rstmid_ovf", OVF, 1'b0);
        p0 = n_pulses;
        ticks(60);
        chk("rstmid_no_nmi", n_pulses - p0, 0);
        chk("rstmid_nmi_low", SCPU_NMI, 1'b0);

        // randomized traffic against the queue model
        en_mode = 2;
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            rd_prob = (seg % 2 == 0) ? 12 : 3;
            for (int i = 0; i < 500; i++) begin
                RESET = ($urandom_range(0, 599) == 0);
                if ($urandom_range(0, 3) == 0) SNDRQ = ~SNDRQ;
                SNDNO = 8'($urandom);
                if ($urandom_range(0, rd_prob) == 0) SCPU_RD = ~SCPU_RD;
                tick();
            end
        end
        RESET = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
